// File: rtl/firebird7_in_gate2_ijtag_seq_pkg.sv
// Shared types and sizing for the gate2 IJTAG access sequencer.
package firebird7_in_gate2_ijtag_seq_pkg;

    // Default number of bits moved per access (also the data-path width).
    localparam int MAX_LEN_DEF = 64;

    // Width needed to hold a length in the range 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    localparam int LEN_W_DEF = len_width(MAX_LEN_DEF);

    // Access phases, in the order an access walks through them.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/firebird7_in_gate2_ijtag_seq_shreg.sv
// Data path of the sequencer: parallel-loaded shift-in register that feeds
// ijtag_si, a bit index counter, and the read-data register that collects
// ijtag_so one bit per shift edge (bit k = k-th bit shifted out).
module firebird7_in_gate2_ijtag_seq_shreg
    import firebird7_in_gate2_ijtag_seq_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = LEN_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,    // request accepted at this edge
    input  logic [MAX_LEN-1:0] wdata_i,
    input  logic               shift_i,   // this edge ends a shift cycle
    input  logic               si_en_i,   // the coming cycle is a shift cycle
    input  logic               so_i,
    output logic               si_o,
    output logic [MAX_LEN-1:0] rdata_o,
    output logic [LEN_W-1:0]   cnt_o
);

    logic [MAX_LEN-1:0] wdata_q, wdata_d;
    logic [MAX_LEN-1:0] rdata_q, rdata_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               si_q, si_d;

    // Next-state: load on accept, otherwise consume one bit per shift edge.
    // si is precomputed from the bit that will be at the head of the
    // register in the coming cycle, so the pin is a plain flop output and
    // stays 0 whenever the coming cycle is not a shift cycle.
    always_comb begin
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        si_d    = 1'b0;
        if (load_i) begin
            wdata_d = wdata_i;
            rdata_d = '0;
            cnt_d   = '0;
        end else if (shift_i) begin
            wdata_d = wdata_q >> 1;
            rdata_d = rdata_q | (MAX_LEN'(so_i) << cnt_q);
            cnt_d   = cnt_q + LEN_W'(1);
        end
        if (si_en_i) begin
            if (load_i) begin
                si_d = wdata_i[0];
            end else if (shift_i) begin
                si_d = wdata_q[1];
            end else begin
                si_d = wdata_q[0];
            end
        end
    end

    // Data-path registers; everything clears on reset so partial read data
    // from an aborted access never survives.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            si_q    <= 1'b0;
        end else begin
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            si_q    <= si_d;
        end
    end

    assign si_o    = si_q;
    assign rdata_o = rdata_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/firebird7_in_gate2_ijtag_access_sequencer.sv
// IJTAG access sequencer for the gate2 SIB network. Each host access runs
// CAPTURE -> SHIFT(len) -> UPDATE and returns the bits seen on ijtag_so.
//
// Host handshake: a request transfers on a rising edge of ijtag_tck where
// req_valid and req_ready are both 1. req_ready is 1 only while idle; a
// request presented while busy is not taken and must be held by the host.
// rsp_valid is a single-cycle pulse; rsp_rdata is valid in that cycle and
// holds until the next request is accepted.
module firebird7_in_gate2_ijtag_access_sequencer
    import firebird7_in_gate2_ijtag_seq_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = 7
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               req_valid,
    input  logic [LEN_W-1:0]   req_len,
    input  logic [MAX_LEN-1:0] req_wdata,
    input  logic               req_no_cap,
    input  logic               req_no_upd,
    output logic               req_ready,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_rdata,
    output logic               busy,
    output logic               ijtag_sel,
    output logic               ijtag_ce,
    output logic               ijtag_se,
    output logic               ijtag_ue,
    output logic               ijtag_si,
    input  logic               ijtag_so,
    output logic [2:0]         dbg_state_o
);

    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    seq_state_e       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             no_upd_q, no_upd_d;

    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             sel_q, sel_d;
    logic             ce_q, ce_d;
    logic             se_q, se_d;
    logic             ue_q, ue_d;

    logic [LEN_W-1:0] len_sat;
    logic [LEN_W-1:0] cnt;
    logic             accept;
    logic             last_shift;

    // Over-long requests are clipped to the data-path width.
    assign len_sat    = (req_len > MAX_LEN_L) ? MAX_LEN_L : req_len;
    assign accept     = req_valid && (state_q == ST_IDLE);
    assign last_shift = (cnt == (len_q - LEN_W'(1)));

    // Next-state logic: phases with nothing to do are skipped, so a
    // len=0 access with both flags set goes straight from IDLE to DONE.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        no_upd_d = no_upd_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    len_d    = len_sat;
                    no_upd_d = req_no_upd;
                    if (!req_no_cap) begin
                        state_d = ST_CAPTURE;
                    end else if (len_sat != '0) begin
                        state_d = ST_SHIFT;
                    end else if (!req_no_upd) begin
                        state_d = ST_UPDATE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (len_q != '0) begin
                    state_d = ST_SHIFT;
                end else if (!no_upd_q) begin
                    state_d = ST_UPDATE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (last_shift) begin
                    state_d = no_upd_q ? ST_DONE : ST_UPDATE;
                end
            end
            ST_UPDATE: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode from the next state, so every control pin is a flop
    // whose value always matches the state it belongs to.
    always_comb begin
        sel_d       = 1'b0;
        ce_d        = 1'b0;
        se_d        = 1'b0;
        ue_d        = 1'b0;
        rsp_valid_d = 1'b0;
        ready_d     = 1'b0;
        busy_d      = 1'b1;
        case (state_d)
            ST_IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            ST_CAPTURE: begin
                sel_d = 1'b1;
                ce_d  = 1'b1;
            end
            ST_SHIFT: begin
                sel_d = 1'b1;
                se_d  = 1'b1;
            end
            ST_UPDATE: begin
                sel_d = 1'b1;
                ue_d  = 1'b1;
            end
            ST_DONE: begin
                rsp_valid_d = 1'b1;
            end
            default: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, latched request fields and registered control outputs.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            no_upd_q    <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            sel_q       <= 1'b0;
            ce_q        <= 1'b0;
            se_q        <= 1'b0;
            ue_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            no_upd_q    <= no_upd_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            sel_q       <= sel_d;
            ce_q        <= ce_d;
            se_q        <= se_d;
            ue_q        <= ue_d;
        end
    end

    firebird7_in_gate2_ijtag_seq_shreg #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_shreg (
        .clk_i   (ijtag_tck),
        .rst_ni  (ijtag_reset),
        .load_i  (accept),
        .wdata_i (req_wdata),
        .shift_i (state_q == ST_SHIFT),
        .si_en_i (state_d == ST_SHIFT),
        .so_i    (ijtag_so),
        .si_o    (ijtag_si),
        .rdata_o (rsp_rdata),
        .cnt_o   (cnt)
    );

    assign req_ready   = ready_q;
    assign busy        = busy_q;
    assign rsp_valid   = rsp_valid_q;
    assign ijtag_sel   = sel_q;
    assign ijtag_ce    = ce_q;
    assign ijtag_se    = se_q;
    assign ijtag_ue    = ue_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_firebird7_in_gate2_ijtag_access_sequencer.sv
// Bench for the gate2 IJTAG access sequencer. A small segment (one SIB
// guarding an 8-bit TDR, order si -> SIB -> TDR[7..0] -> so) hangs off the
// scan pins. Expected read data comes from a queue-based model of that
// segment; a monitor pops the expectations when rsp_valid pulses.
module tb_firebird7_in_gate2_ijtag_access_sequencer;
  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic               req_valid = 1'b0;
  logic [LEN_W-1:0]   req_len = '0;
  logic [MAX_LEN-1:0] req_wdata = '0;
  logic               req_no_cap = 1'b0;
  logic               req_no_upd = 1'b0;
  logic               req_ready, rsp_valid, busy;
  logic [MAX_LEN-1:0] rsp_rdata;
  logic               sel, ce, se, ue, si, so;
  logic [2:0]         dbg_state;

  firebird7_in_gate2_ijtag_access_sequencer #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) dut (
    .ijtag_tck   (clk),
    .ijtag_reset (rst_n),
    .req_valid   (req_valid),
    .req_len     (req_len),
    .req_wdata   (req_wdata),
    .req_no_cap  (req_no_cap),
    .req_no_upd  (req_no_upd),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .ijtag_sel   (sel),
    .ijtag_ce    (ce),
    .ijtag_se    (se),
    .ijtag_ue    (ue),
    .ijtag_si    (si),
    .ijtag_so    (so),
    .dbg_state_o (dbg_state)
  );

  // ---------------- segment under the sequencer ----------------
  logic       seg_sib_upd, seg_sib_sh;
  logic [7:0] seg_tdr_upd, seg_tdr_sh;

  assign so = seg_sib_upd ? seg_tdr_sh[0] : seg_sib_sh;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sib_sh <= 1'b0;
      seg_tdr_sh <= '0;
    end else if (sel && ce) begin
      seg_sib_sh <= seg_sib_upd;
      if (seg_sib_upd) seg_tdr_sh <= seg_tdr_upd;
    end else if (sel && se) begin
      seg_sib_sh <= si;
      if (seg_sib_upd) seg_tdr_sh <= {seg_sib_sh, seg_tdr_sh[7:1]};
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_sib_upd <= 1'b0;
      seg_tdr_upd <= '0;
    end else if (sel && ue) begin
      seg_sib_upd <= seg_sib_sh;
      if (seg_sib_upd) seg_tdr_upd <= seg_tdr_sh;
    end
  end

  // ---------------- reference model ----------------
  bit       m_sib_upd, m_sib_sh;
  bit [7:0] m_tdr_upd, m_tdr_sh;

  function automatic void model_reset();
    m_sib_upd = 1'b0;
    m_sib_sh  = 1'b0;
    m_tdr_upd = '0;
    m_tdr_sh  = '0;
  endfunction

  // Scan path as a list of bits, so-end first: shifting pops the front
  // into the read data and appends the next write bit at the back.
  function automatic logic [MAX_LEN-1:0] model_access(input int len_raw,
      input logic [MAX_LEN-1:0] wdata, input bit nc, input bit nu);
    int n;
    bit q[$];
    bit was_open;
    logic [MAX_LEN-1:0] r;
    n = (len_raw > MAX_LEN) ? MAX_LEN : len_raw;
    r = '0;
    was_open = m_sib_upd;
    if (!nc) begin
      m_sib_sh = m_sib_upd;
      if (was_open) m_tdr_sh = m_tdr_upd;
    end
    if (was_open) for (int i = 0; i < 8; i++) q.push_back(m_tdr_sh[i]);
    q.push_back(m_sib_sh);
    for (int i = 0; i < n; i++) begin
      r[i] = q.pop_front();
      q.push_back(wdata[i]);
    end
    if (was_open) begin
      for (int i = 0; i < 8; i++) m_tdr_sh[i] = q[i];
      m_sib_sh = q[8];
    end else begin
      m_sib_sh = q[0];
    end
    if (!nu) begin
      m_sib_upd = m_sib_sh;
      if (was_open) m_tdr_upd = m_tdr_sh;
    end
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [MAX_LEN-1:0] exp_q[$];
  int                 exp_acc_q[$];
  int                 exp_lat_q[$];
  logic [31:0]        exp_ctl_q[$];
  logic [MAX_LEN-1:0] last_exp = '0;

  function automatic void check(input string name, input logic [63:0] act,
      input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void flush_expected();
    exp_q.delete();
    exp_acc_q.delete();
    exp_lat_q.delete();
    exp_ctl_q.delete();
  endfunction

  // ---------------- monitor ----------------
  int n_ce = 0, n_se = 0, n_ue = 0, n_sel = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      n_ce = 0; n_se = 0; n_ue = 0; n_sel = 0;
    end else begin
      if (sel || ce || se || ue)
        check("scan_ctl_onehot_with_sel", {63'd0, sel && $onehot({ce, se, ue})}, 64'd1);
      n_ce += int'(ce);
      n_se += int'(se);
      n_ue += int'(ue);
      n_sel += int'(sel);
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid with nothing outstanding (t=%0t)", $time);
        end else begin
          logic [MAX_LEN-1:0] e;
          int acc, lat;
          logic [31:0] ctl;
          e = exp_q.pop_front();
          acc = exp_acc_q.pop_front();
          lat = exp_lat_q.pop_front();
          ctl = exp_ctl_q.pop_front();
          check("rsp_rdata", rsp_rdata, e);
          // cycles from the accept cycle through the response cycle
          check("rsp_latency", 64'(cyc - acc + 2), 64'(lat));
          check("scan_ctl_counts", {32'd0, 8'(n_ce), 8'(n_se), 8'(n_ue), 8'(n_sel)}, {32'd0, ctl});
        end
        n_ce = 0; n_se = 0; n_ue = 0; n_sel = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after the accept edge with
  // req_valid still high so the caller can hold a follow-up request.
  task automatic issue(input int len, input logic [MAX_LEN-1:0] wdata,
      input bit nc, input bit nu);
    int guard, n;
    logic [MAX_LEN-1:0] e;
    req_valid  = 1'b1;
    req_len    = LEN_W'(len);
    req_wdata  = wdata;
    req_no_cap = nc;
    req_no_upd = nu;
    guard = 0;
    while (!req_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", guard);
      return;
    end
    check("rdata_hold_until_accept", rsp_rdata, last_exp);
    n = (len > MAX_LEN) ? MAX_LEN : len;
    e = model_access(len, wdata, nc, nu);
    last_exp = e;
    exp_q.push_back(e);
    exp_acc_q.push_back(cyc + 1);
    exp_lat_q.push_back(1 + int'(!nc) + n + int'(!nu) + 1);
    exp_ctl_q.push_back({8'(!nc), 8'(n), 8'(!nu), 8'(int'(!nc) + n + int'(!nu))});
    @(negedge clk);
  endtask

  task automatic release_req();
    req_valid = 1'b0;
    req_wdata = {$urandom, $urandom};
    req_len   = LEN_W'($urandom_range(0, 127));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, {56'd0, req_ready, rsp_valid, busy, sel, ce, se, ue, si}, 64'h80);
    check({name, "_rdata"}, rsp_rdata, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len, r;
    model_reset();
    idle(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // open the SIB
    issue(1, 64'h1, 1'b0, 1'b0);
    release_req(); idle(2);
    // SIB + TDR: first read returns the old TDR, second returns 0xA5
    issue(9, 64'h1A5, 1'b0, 1'b0);
    release_req(); idle(1);
    issue(9, 64'h1A5, 1'b0, 1'b0);
    release_req(); idle(1);
    // nothing to capture, shift or update
    issue(0, {$urandom, $urandom}, 1'b1, 1'b1);
    release_req(); idle(3);
    // over-long request saturates
    issue(100, {$urandom, $urandom}, 1'b0, 1'b0);
    release_req(); idle(1);
    // request held while busy, with different data
    issue(12, {$urandom, $urandom}, 1'b0, 1'b0);
    issue(5, {$urandom, $urandom}, 1'b0, 1'b1);
    release_req(); idle(2);

    // async reset in the third shift cycle
    issue(10, {$urandom, $urandom}, 1'b0, 1'b0);
    release_req();
    idle(3);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    flush_expected();
    model_reset();
    last_exp = '0;
    @(negedge clk);
    check("rsp_in_reset", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    issue(1, 64'h1, 1'b0, 1'b0);
    release_req(); idle(1);
    issue(9, 64'h3C, 1'b0, 1'b0);
    release_req(); idle(1);

    // randomized accesses, some held back-to-back
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) len = 0;
      else if (r == 1) len = MAX_LEN;
      else if (r == 2) len = 127;
      else len = $urandom_range(1, 70);
      issue(len, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) begin
        release_req();
        idle($urandom_range(0, 3));
      end
    end
    release_req();

    // drain
    for (int g = 0; g < 500 && exp_q.size() != 0; g++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
